// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the control pipeline: branch, next-PC and forward
// encodings plus the packed per-stage control word.
package ctrl_pipeline_pkg;

    localparam int unsigned ALU_CTRL_W = 3;
    localparam int unsigned BR_W       = 2;
    localparam int unsigned PC_SRC_W   = 2;
    localparam int unsigned FW_W       = 2;

    // Branch type carried with the instruction (11 behaves as none)
    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_EQ   = 2'b01;
    localparam logic [BR_W-1:0] BR_NE   = 2'b10;

    // Next-PC select
    localparam logic [PC_SRC_W-1:0] PC_SEQ = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_BR  = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_JMP = 2'b10;

    // EX operand source select
    localparam logic [FW_W-1:0] FW_RF  = 2'b00;
    localparam logic [FW_W-1:0] FW_WB  = 2'b01;
    localparam logic [FW_W-1:0] FW_MEM = 2'b10;

    // Control bits held in the ID/EX register
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  alu_src;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic [BR_W-1:0]       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Branch outcome from the branch type and the ALU zero flag
    function automatic logic branch_taken(input logic [BR_W-1:0] br, input logic zero);
        logic taken;
        case (br)
            BR_NONE: taken = 1'b0;
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Control-pipeline bus: ID-stage decoded controls in, per-stage controls and
// hazard enables out. Statistics counters exist only with CTRL_PIPE_STATS_EN.
interface ctrl_pipeline_if #(
    parameter int unsigned REG_AW = 5
`ifdef CTRL_PIPE_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
);
    // ID stage
    logic              id_RegWrite;
    logic              id_MemtoReg;
    logic              id_MemWrite;
    logic              id_AluSrc;
    logic              id_RegDst;
    logic              id_Jump;
    logic [2:0]        id_AluControl;
    logic [1:0]        id_Branch;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_zero;

    // EX stage
    logic              ex_RegWrite;
    logic              ex_MemtoReg;
    logic              ex_MemWrite;
    logic              ex_AluSrc;
    logic [2:0]        ex_AluControl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_wreg;

    // MEM and WB stages
    logic              mem_RegWrite;
    logic              mem_MemtoReg;
    logic              mem_MemWrite;
    logic [REG_AW-1:0] mem_wreg;
    logic              wb_RegWrite;
    logic              wb_MemtoReg;
    logic [REG_AW-1:0] wb_wreg;

    // Hazard control
    logic [1:0]        pc_src;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;

`ifdef CTRL_PIPE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    modport master (
        output id_RegWrite, id_MemtoReg, id_MemWrite, id_AluSrc, id_RegDst, id_Jump,
        output id_AluControl, id_Branch, id_rs, id_rt, id_rd, ex_zero,
        input  ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_AluSrc, ex_AluControl,
        input  ex_rs, ex_rt, ex_wreg,
        input  mem_RegWrite, mem_MemtoReg, mem_MemWrite, mem_wreg,
        input  wb_RegWrite, wb_MemtoReg, wb_wreg,
        input  pc_src, StallF, StallD, FlushD, FlushE, ForwardA, ForwardB
`ifdef CTRL_PIPE_STATS_EN
        ,
        input  stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_RegWrite, id_MemtoReg, id_MemWrite, id_AluSrc, id_RegDst, id_Jump,
        input  id_AluControl, id_Branch, id_rs, id_rt, id_rd, ex_zero,
        output ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_AluSrc, ex_AluControl,
        output ex_rs, ex_rt, ex_wreg,
        output mem_RegWrite, mem_MemtoReg, mem_MemWrite, mem_wreg,
        output wb_RegWrite, wb_MemtoReg, wb_wreg,
        output pc_src, StallF, StallD, FlushD, FlushE, ForwardA, ForwardB
`ifdef CTRL_PIPE_STATS_EN
        ,
        output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/ctrl_pipeline_hazard_unit.sv
// Combinational hazard resolution: branch-taken redirect, load-use stall,
// jump redirect (priority branch > stall > jump) and EX forwarding selects.
// Everything is forced quiet while reset is asserted.
module ctrl_pipeline_hazard_unit
    import ctrl_pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic                rst_n,
    input  logic [BR_W-1:0]     ex_branch,
    input  logic                ex_zero,
    input  logic                ex_mem_to_reg,
    input  logic [REG_AW-1:0]   ex_wreg,
    input  logic [REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]   ex_rt,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                id_jump,
    input  logic                mem_reg_write,
    input  logic [REG_AW-1:0]   mem_wreg,
    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_wreg,
    output logic [PC_SRC_W-1:0] pc_src_c,
    output logic                stall_f_c,
    output logic                stall_d_c,
    output logic                flush_d_c,
    output logic                flush_e_c,
    output logic [FW_W-1:0]     forward_a_c,
    output logic [FW_W-1:0]     forward_b_c
`ifdef CTRL_PIPE_STATS_EN
    ,
    output logic                br_taken_c,
    output logic                lw_stall_c
`endif
);

    logic br_taken;
    logic lw_hit;

    // Operand source: newest in-flight writer of src wins, register 0 never forwards
    function automatic logic [FW_W-1:0] fwd_sel(
        input logic              m_rw,
        input logic [REG_AW-1:0] m_reg,
        input logic              w_rw,
        input logic [REG_AW-1:0] w_reg,
        input logic [REG_AW-1:0] src
    );
        logic [FW_W-1:0] sel;
        sel = FW_RF;
        if (m_rw && (m_reg != '0) && (m_reg == src)) begin
            sel = FW_MEM;
        end else if (w_rw && (w_reg != '0) && (w_reg == src)) begin
            sel = FW_WB;
        end
        return sel;
    endfunction

    // Raw branch outcome and load-use match
    always_comb begin
        br_taken = 1'b0;
        lw_hit   = 1'b0;
        if (rst_n) begin
            br_taken = branch_taken(ex_branch, ex_zero);
            lw_hit   = ex_mem_to_reg && (ex_wreg != '0) &&
                       ((ex_wreg == id_rs) || (ex_wreg == id_rt));
        end
    end

    // Redirect, stall and flush; a squashing branch overrides the stall,
    // and a stall defers the jump until it is re-presented
    always_comb begin
        pc_src_c  = PC_SEQ;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        if (br_taken) begin
            pc_src_c  = PC_BR;
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
        end else if (lw_hit) begin
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
        end else if (rst_n && id_jump) begin
            pc_src_c  = PC_JMP;
            flush_d_c = 1'b1;
        end
    end

    // EX operand forwarding selects
    always_comb begin
        forward_a_c = FW_RF;
        forward_b_c = FW_RF;
        if (rst_n) begin
            forward_a_c = fwd_sel(mem_reg_write, mem_wreg, wb_reg_write, wb_wreg, ex_rs);
            forward_b_c = fwd_sel(mem_reg_write, mem_wreg, wb_reg_write, wb_wreg, ex_rt);
        end
    end

`ifdef CTRL_PIPE_STATS_EN
    assign br_taken_c = br_taken;
    assign lw_stall_c = lw_hit && !br_taken;
`endif

endmodule

// File: rtl/ctrl_pipeline.sv
// Control pipeline: carries decoded controls through ID/EX, EX/MEM and MEM/WB
// and drives the datapath stall/flush/forward controls.
// Optional CTRL_PIPE_STATS_EN adds saturating stall/flush event counters.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
`ifdef CTRL_PIPE_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    ctrl_pipeline_if.slave bus
);

    ctrl_t             id_ctrl;
    logic [REG_AW-1:0] id_wreg;

    ctrl_t             ex_ctrl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_wreg;

    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic              mem_mem_write;
    logic [REG_AW-1:0] mem_wreg;

    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_wreg;

    logic              flush_e;

`ifdef CTRL_PIPE_STATS_EN
    logic              br_taken;
    logic              lw_stall;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    // Pack ID controls; destination is resolved here so EX holds it directly
    always_comb begin
        id_ctrl             = CTRL_BUBBLE;
        id_ctrl.reg_write   = bus.id_RegWrite;
        id_ctrl.mem_to_reg  = bus.id_MemtoReg;
        id_ctrl.mem_write   = bus.id_MemWrite;
        id_ctrl.alu_src     = bus.id_AluSrc;
        id_ctrl.alu_control = bus.id_AluControl;
        id_ctrl.branch      = bus.id_Branch;
    end

    assign id_wreg = bus.id_RegDst ? bus.id_rd : bus.id_rt;

    ctrl_pipeline_hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .rst_n         (reset),
        .ex_branch     (ex_ctrl.branch),
        .ex_zero       (bus.ex_zero),
        .ex_mem_to_reg (ex_ctrl.mem_to_reg),
        .ex_wreg       (ex_wreg),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .id_rs         (bus.id_rs),
        .id_rt         (bus.id_rt),
        .id_jump       (bus.id_Jump),
        .mem_reg_write (mem_reg_write),
        .mem_wreg      (mem_wreg),
        .wb_reg_write  (wb_reg_write),
        .wb_wreg       (wb_wreg),
        .pc_src_c      (bus.pc_src),
        .stall_f_c     (bus.StallF),
        .stall_d_c     (bus.StallD),
        .flush_d_c     (bus.FlushD),
        .flush_e_c     (flush_e),
        .forward_a_c   (bus.ForwardA),
        .forward_b_c   (bus.ForwardB)
`ifdef CTRL_PIPE_STATS_EN
        ,
        .br_taken_c    (br_taken),
        .lw_stall_c    (lw_stall)
`endif
    );

    assign bus.FlushE = flush_e;

    // ID/EX register: bubble on flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_wreg <= '0;
        end else if (flush_e) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_rs   <= '0;
            ex_rt   <= '0;
            ex_wreg <= '0;
        end else begin
            ex_ctrl <= id_ctrl;
            ex_rs   <= bus.id_rs;
            ex_rt   <= bus.id_rt;
            ex_wreg <= id_wreg;
        end
    end

    // EX/MEM register: free-running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_wreg       <= '0;
        end else begin
            mem_reg_write  <= ex_ctrl.reg_write;
            mem_mem_to_reg <= ex_ctrl.mem_to_reg;
            mem_mem_write  <= ex_ctrl.mem_write;
            mem_wreg       <= ex_wreg;
        end
    end

    // MEM/WB register: free-running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_wreg       <= '0;
        end else begin
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_mem_to_reg;
            wb_wreg       <= mem_wreg;
        end
    end

`ifdef CTRL_PIPE_STATS_EN
    // Saturating counts of effective load-use stalls and branch flushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lw_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_e && br_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
`endif

    assign bus.ex_RegWrite   = ex_ctrl.reg_write;
    assign bus.ex_MemtoReg   = ex_ctrl.mem_to_reg;
    assign bus.ex_MemWrite   = ex_ctrl.mem_write;
    assign bus.ex_AluSrc     = ex_ctrl.alu_src;
    assign bus.ex_AluControl = ex_ctrl.alu_control;
    assign bus.ex_rs         = ex_rs;
    assign bus.ex_rt         = ex_rt;
    assign bus.ex_wreg       = ex_wreg;

    assign bus.mem_RegWrite  = mem_reg_write;
    assign bus.mem_MemtoReg  = mem_mem_to_reg;
    assign bus.mem_MemWrite  = mem_mem_write;
    assign bus.mem_wreg      = mem_wreg;

    assign bus.wb_RegWrite   = wb_reg_write;
    assign bus.wb_MemtoReg   = wb_mem_to_reg;
    assign bus.wb_wreg       = wb_wreg;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed scenarios with literal expectations, then
// randomized instruction streams compared every cycle against a stage-array
// model. Acts as the datapath: holds the ID word on stall, inserts a NOP on FlushD.
module tb_ctrl_pipeline;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset;

    always #10 clk = ~clk;

    ctrl_pipeline_if bus ();

    ctrl_pipeline dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction as presented in ID
    typedef struct packed {
        logic          rw;
        logic          m2r;
        logic          mw;
        logic          asrc;
        logic          rdst;
        logic          jmp;
        logic [2:0]    alu;
        logic [1:0]    br;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } id_t;

    // Instruction occupying a pipeline slot
    typedef struct packed {
        logic          rw;
        logic          m2r;
        logic          mw;
        logic          asrc;
        logic [2:0]    alu;
        logic [1:0]    br;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] wreg;
    } slot_t;

    int checks = 0;
    int errors = 0;

    slot_t pipe [3];          // 0 = EX, 1 = MEM, 2 = WB
    logic  exp_stall   = 1'b0;
    logic  exp_flush_d = 1'b0;
    int    exp_scnt    = 0;
    int    exp_fcnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input slot_t m, input slot_t w, input logic [AW-1:0] src);
        if (m.rw && m.wreg != 0 && m.wreg == src) return 2'b10;
        if (w.rw && w.wreg != 0 && w.wreg == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic compare(input slot_t ex, input slot_t mem, input slot_t wb,
                           input logic [1:0] pc, input logic sf, input logic sd,
                           input logic fd, input logic fe,
                           input logic [1:0] fa, input logic [1:0] fb);
        chk("ex_RegWrite",   32'(bus.ex_RegWrite),   32'(ex.rw));
        chk("ex_MemtoReg",   32'(bus.ex_MemtoReg),   32'(ex.m2r));
        chk("ex_MemWrite",   32'(bus.ex_MemWrite),   32'(ex.mw));
        chk("ex_AluSrc",     32'(bus.ex_AluSrc),     32'(ex.asrc));
        chk("ex_AluControl", 32'(bus.ex_AluControl), 32'(ex.alu));
        chk("ex_rs",         32'(bus.ex_rs),         32'(ex.rs));
        chk("ex_rt",         32'(bus.ex_rt),         32'(ex.rt));
        chk("ex_wreg",       32'(bus.ex_wreg),       32'(ex.wreg));
        chk("mem_RegWrite",  32'(bus.mem_RegWrite),  32'(mem.rw));
        chk("mem_MemtoReg",  32'(bus.mem_MemtoReg),  32'(mem.m2r));
        chk("mem_MemWrite",  32'(bus.mem_MemWrite),  32'(mem.mw));
        chk("mem_wreg",      32'(bus.mem_wreg),      32'(mem.wreg));
        chk("wb_RegWrite",   32'(bus.wb_RegWrite),   32'(wb.rw));
        chk("wb_MemtoReg",   32'(bus.wb_MemtoReg),   32'(wb.m2r));
        chk("wb_wreg",       32'(bus.wb_wreg),       32'(wb.wreg));
        chk("pc_src",        32'(bus.pc_src),        32'(pc));
        chk("StallF",        32'(bus.StallF),        32'(sf));
        chk("StallD",        32'(bus.StallD),        32'(sd));
        chk("FlushD",        32'(bus.FlushD),        32'(fd));
        chk("FlushE",        32'(bus.FlushE),        32'(fe));
        chk("ForwardA",      32'(bus.ForwardA),      32'(fa));
        chk("ForwardB",      32'(bus.ForwardB),      32'(fb));
`ifdef CTRL_PIPE_STATS_EN
        chk("stall_cnt",     32'(bus.stall_cnt),     32'(exp_scnt));
        chk("flush_cnt",     32'(bus.flush_cnt),     32'(exp_fcnt));
`endif
    endtask

    // Reference model and per-cycle compare; the model then advances to the
    // state the coming rising edge must produce
    always @(negedge clk) begin
        slot_t      ex, mem, wb, nxt;
        logic       taken, load_use, sf, fd, fe;
        logic [1:0] pc;
        if (!reset) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            exp_scnt    = 0;
            exp_fcnt    = 0;
            exp_stall   = 1'b0;
            exp_flush_d = 1'b0;
            compare('0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        end else begin
            ex  = pipe[0];
            mem = pipe[1];
            wb  = pipe[2];
            taken    = (ex.br == 2'b01 && bus.ex_zero) || (ex.br == 2'b10 && !bus.ex_zero);
            load_use = ex.m2r && ex.wreg != 0 && (ex.wreg == bus.id_rs || ex.wreg == bus.id_rt);
            pc = 2'b00; sf = 1'b0; fd = 1'b0; fe = 1'b0;
            if (taken) begin
                pc = 2'b01; fd = 1'b1; fe = 1'b1;
            end else if (load_use) begin
                sf = 1'b1; fe = 1'b1;
            end else if (bus.id_Jump) begin
                pc = 2'b10; fd = 1'b1;
            end
            compare(ex, mem, wb, pc, sf, sf, fd, fe, fwd(mem, wb, ex.rs), fwd(mem, wb, ex.rt));

            nxt = '0;
            if (!fe) begin
                nxt.rw   = bus.id_RegWrite;
                nxt.m2r  = bus.id_MemtoReg;
                nxt.mw   = bus.id_MemWrite;
                nxt.asrc = bus.id_AluSrc;
                nxt.alu  = bus.id_AluControl;
                nxt.br   = bus.id_Branch;
                nxt.rs   = bus.id_rs;
                nxt.rt   = bus.id_rt;
                nxt.wreg = bus.id_RegDst ? bus.id_rd : bus.id_rt;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
            if (taken && exp_fcnt < (1 << CW) - 1) exp_fcnt++;
            if (load_use && !taken && exp_scnt < (1 << CW) - 1) exp_scnt++;
            exp_stall   = sf;
            exp_flush_d = fd;
        end
    end

    task automatic drive(input id_t w, input logic z);
        bus.id_RegWrite   = w.rw;
        bus.id_MemtoReg   = w.m2r;
        bus.id_MemWrite   = w.mw;
        bus.id_AluSrc     = w.asrc;
        bus.id_RegDst     = w.rdst;
        bus.id_Jump       = w.jmp;
        bus.id_AluControl = w.alu;
        bus.id_Branch     = w.br;
        bus.id_rs         = w.rs;
        bus.id_rt         = w.rt;
        bus.id_rd         = w.rd;
        bus.ex_zero       = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic id_t rand_word();
        id_t w;
        w.rw   = 1'($urandom_range(0, 1));
        w.m2r  = ($urandom_range(0, 2) == 0);
        w.mw   = 1'($urandom_range(0, 1));
        w.asrc = 1'($urandom_range(0, 1));
        w.rdst = 1'($urandom_range(0, 1));
        w.jmp  = ($urandom_range(0, 7) == 0);
        w.alu  = 3'($urandom_range(0, 7));
        w.br   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        w.rs   = AW'($urandom_range(0, 3));
        w.rt   = AW'($urandom_range(0, 3));
        w.rd   = AW'($urandom_range(0, 3));
        return w;
    endfunction

    // lw to r followed by a dependent consumer held across its stall
    task automatic load_use_event(input logic [AW-1:0] r);
        id_t w;
        w = '0; w.rw = 1'b1; w.m2r = 1'b1; w.asrc = 1'b1; w.rt = r;
        drive(w, 1'b0); tick();
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rs = r; w.rd = 5'd9;
        drive(w, 1'b0); tick();
        drive(w, 1'b0); tick();
        drive('0, 1'b0); tick();
    endtask

    initial begin
        id_t w;
        id_t cur;
        reset = 1'b0;
        drive('0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pc_src", 32'(bus.pc_src), 32'd0);
        chk("rst_FlushE", 32'(bus.FlushE), 32'd0);
        reset = 1'b1;

        // Propagation of a register-writing instruction to rd=5
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rd = 5'd5; w.rt = 5'd2;
        drive(w, 1'b0); tick();
        drive('0, 1'b0); #1;
        chk("prop_ex_wreg", 32'(bus.ex_wreg), 32'd5);
        chk("prop_ex_rw", 32'(bus.ex_RegWrite), 32'd1);
        tick(); #1;
        chk("prop_mem_wreg", 32'(bus.mem_wreg), 32'd5);
        tick(); #1;
        chk("prop_wb_rw", 32'(bus.wb_RegWrite), 32'd1);
        chk("prop_wb_wreg", 32'(bus.wb_wreg), 32'd5);
        tick();

        // Load-use on r8: one stall cycle, bubble, then WB forward
        w = '0; w.rw = 1'b1; w.m2r = 1'b1; w.asrc = 1'b1; w.rs = 5'd1; w.rt = 5'd8; w.alu = 3'd2;
        drive(w, 1'b0); tick();
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rs = 5'd8; w.rt = 5'd2; w.rd = 5'd9; w.alu = 3'd2;
        drive(w, 1'b0); #1;
        chk("lu_StallF", 32'(bus.StallF), 32'd1);
        chk("lu_StallD", 32'(bus.StallD), 32'd1);
        chk("lu_FlushE", 32'(bus.FlushE), 32'd1);
        tick();
        drive(w, 1'b0); #1;
        chk("lu_once_StallF", 32'(bus.StallF), 32'd0);
        chk("lu_bubble_rw", 32'(bus.ex_RegWrite), 32'd0);
        chk("lu_mem_wreg", 32'(bus.mem_wreg), 32'd8);
        tick();
        drive('0, 1'b0); #1;
        chk("lu_ex_rs", 32'(bus.ex_rs), 32'd8);
        chk("lu_ForwardA_wb", 32'(bus.ForwardA), 32'd1);
        tick();

        // Forward priority: MEM and WB both write r3
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rd = 5'd3;
        drive(w, 1'b0); tick();
        drive(w, 1'b0); tick();
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rs = 5'd3; w.rt = 5'd3; w.rd = 5'd4;
        drive(w, 1'b0); tick();
        drive('0, 1'b0); #1;
        chk("fw_prio_A", 32'(bus.ForwardA), 32'd2);
        chk("fw_prio_B", 32'(bus.ForwardB), 32'd2);
        tick();
        // Same with register 0
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rd = 5'd0;
        drive(w, 1'b0); tick();
        drive(w, 1'b0); tick();
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rd = 5'd4;
        drive(w, 1'b0); tick();
        drive('0, 1'b0); #1;
        chk("fw_r0_A", 32'(bus.ForwardA), 32'd0);
        tick();

        // beq taken / not taken, then bne taken
        w = '0; w.br = 2'b01; w.rs = 5'd1; w.rt = 5'd1;
        drive(w, 1'b0); tick();
        drive('0, 1'b1); #1;
        chk("beq_pc_src", 32'(bus.pc_src), 32'd1);
        chk("beq_FlushD", 32'(bus.FlushD), 32'd1);
        chk("beq_FlushE", 32'(bus.FlushE), 32'd1);
        bus.ex_zero = 1'b0; #1;
        chk("beq_nt_pc_src", 32'(bus.pc_src), 32'd0);
        chk("beq_nt_FlushE", 32'(bus.FlushE), 32'd0);
        tick();
        w = '0; w.br = 2'b10; w.rs = 5'd1; w.rt = 5'd2;
        drive(w, 1'b0); tick();
        drive('0, 1'b0); #1;
        chk("bne_pc_src", 32'(bus.pc_src), 32'd1);
        chk("bne_FlushD", 32'(bus.FlushD), 32'd1);
        chk("bne_FlushE", 32'(bus.FlushE), 32'd1);
        tick();

        // Taken branch overrides a load-use in ID
        w = '0; w.br = 2'b01; w.m2r = 1'b1; w.rw = 1'b1; w.rs = 5'd1; w.rt = 5'd4;
        drive(w, 1'b0); tick();
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rs = 5'd4; w.rt = 5'd5; w.rd = 5'd6;
        drive(w, 1'b1); #1;
        chk("sim_StallF", 32'(bus.StallF), 32'd0);
        chk("sim_FlushE", 32'(bus.FlushE), 32'd1);
        chk("sim_pc_src", 32'(bus.pc_src), 32'd1);
        tick();
        drive('0, 1'b0); tick();

        // Jump in ID during a stall is deferred one cycle
        w = '0; w.rw = 1'b1; w.m2r = 1'b1; w.rt = 5'd6;
        drive(w, 1'b0); tick();
        w = '0; w.jmp = 1'b1; w.rs = 5'd6;
        drive(w, 1'b0); #1;
        chk("jst_pc_src", 32'(bus.pc_src), 32'd0);
        chk("jst_StallF", 32'(bus.StallF), 32'd1);
        tick();
        drive(w, 1'b0); #1;
        chk("jmp_pc_src", 32'(bus.pc_src), 32'd2);
        chk("jmp_FlushD", 32'(bus.FlushD), 32'd1);
        tick();
        drive('0, 1'b0); tick();

        // Asynchronous reset with a store in MEM and a jump in ID
        w = '0; w.mw = 1'b1; w.rs = 5'd1; w.rt = 5'd2;
        drive(w, 1'b0); tick();
        w = '0; w.rw = 1'b1; w.rdst = 1'b1; w.rd = 5'd7;
        drive(w, 1'b0); tick();
        w = '0; w.jmp = 1'b1;
        drive(w, 1'b0); #1;
        chk("pre_rst_mem_mw", 32'(bus.mem_MemWrite), 32'd1);
        chk("pre_rst_pc_src", 32'(bus.pc_src), 32'd2);
        reset = 1'b0; #1;
        chk("arst_mem_mw", 32'(bus.mem_MemWrite), 32'd0);
        chk("arst_ex_rw", 32'(bus.ex_RegWrite), 32'd0);
        chk("arst_pc_src", 32'(bus.pc_src), 32'd0);
        chk("arst_FlushD", 32'(bus.FlushD), 32'd0);
        drive('0, 1'b0);
        tick(); tick();
        reset = 1'b1;
`ifdef CTRL_PIPE_STATS_EN
        #1;
        chk("cnt_rst_stall", 32'(bus.stall_cnt), 32'd0);
        chk("cnt_rst_flush", 32'(bus.flush_cnt), 32'd0);
        tick();
`endif
        load_use_event(5'd3);
        load_use_event(5'd7);
        load_use_event(5'd12);
`ifdef CTRL_PIPE_STATS_EN
        #1;
        chk("cnt_stall_3", 32'(bus.stall_cnt), 32'd3);
        tick();
`endif

        // Random stream, datapath emulated from the model's stall/flush decisions
        cur = '0;
        for (int k = 0; k < 3000; k++) begin
            if (!exp_stall) begin
                cur = exp_flush_d ? id_t'('0) : rand_word();
            end
            drive(cur, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
